// File: rtl/seq_pattern_tx_if.sv
// seq_pattern_tx_if: start/pattern request and serial bit stream of the pattern transmitter
interface seq_pattern_tx_if #(
    parameter int LEN = 8,
    parameter int CW  = $clog2(LEN) + 1
);
    logic           start;
    logic [LEN-1:0] pattern;
    logic [CW-1:0]  nbits;
    logic           repeat_en;
    logic           x;
    logic           bit_valid;
    logic           busy;
    logic           done;
    modport master (output start, pattern, nbits, repeat_en, input x, bit_valid, busy, done);
    modport slave  (input start, pattern, nbits, repeat_en, output x, bit_valid, busy, done);
endinterface

// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: shifts a 1..LEN bit pattern out MSB first, DIV clocks per bit, optional repeat
module seq_pattern_tx #(
    parameter int DIV = 3,
    parameter int LEN = 8,
    parameter int CW  = $clog2(LEN) + 1
) (
    input logic           clk,
    input logic           rst,
    seq_pattern_tx_if.slave bus
);
    localparam int DW = DIV > 1 ? $clog2(DIV) : 1;
    typedef enum logic {IDLE, SEND} state_t;
    state_t         state, state_d;
    logic [LEN-1:0] pat_q, pat_d;
    logic [CW-1:0]  n_q, n_d, idx_q, idx_d;
    logic [DW-1:0]  div_q, div_d;
    logic           done_q, done_d;
    logic           last_div;
    // rst is active-low; outputs derive only from registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            pat_q  <= '0;
            n_q    <= '0;
            idx_q  <= '0;
            div_q  <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_d;
            pat_q  <= pat_d;
            n_q    <= n_d;
            idx_q  <= idx_d;
            div_q  <= div_d;
            done_q <= done_d;
        end
    end
    assign last_div = div_q == DW'(DIV - 1);
    always_comb begin
        state_d = state;
        pat_d   = pat_q;
        n_d     = n_q;
        idx_d   = idx_q;
        div_d   = div_q;
        done_d  = 1'b0;
        if (state == IDLE) begin
            if (bus.start && bus.nbits != '0 && bus.nbits <= CW'(LEN)) begin
                state_d = SEND;
                pat_d   = bus.pattern;
                n_d     = bus.nbits;
                idx_d   = bus.nbits - CW'(1);
                div_d   = '0;
            end
        end else begin
            div_d = last_div ? '0 : div_q + DW'(1);
            if (last_div) begin
                if (idx_q != '0) idx_d = idx_q - CW'(1);
                else if (bus.repeat_en) idx_d = n_q - CW'(1);
                else begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
        end
    end
    assign bus.x         = (state == SEND) & |(pat_q & (LEN'(1) << idx_q));
    assign bus.bit_valid = (state == SEND) && div_q == '0;
    assign bus.busy      = state == SEND;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_seq_pattern_tx.sv
// tb_seq_pattern_tx: scoreboard bench; expected {x,bit_valid,busy,done} per cycle queued at stimulus time
module tb_seq_pattern_tx;
    localparam int DIV = 3;
    localparam int LEN = 8;
    localparam int CW  = $clog2(LEN) + 1;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tests = 0;
    int   fails = 0;
    logic [3:0] q[$];
    seq_pattern_tx_if #(.LEN(LEN), .CW(CW)) bus();
    seq_pattern_tx #(.DIV(DIV), .LEN(LEN)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic push_idle(int n);
        repeat (n) q.push_back(4'b0000);
    endtask
    task automatic push_xfer(logic [LEN-1:0] pat, int n, int periods, bit fin);
        for (int p = 0; p < periods; p++)
            for (int j = n - 1; j >= 0; j--)
                for (int d = 0; d < DIV; d++)
                    q.push_back({pat[j], d == 0, 1'b1, 1'b0});
        if (fin) q.push_back(4'b0001);
    endtask
    // compares the current cycle, then advances to 1 time unit after the next edge
    task automatic check_cycles(string name, int n);
        for (int i = 0; i < n; i++) begin
            logic [3:0] obs;
            logic [3:0] exp;
            obs = {bus.x, bus.bit_valid, bus.busy, bus.done};
            tests++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL %s cycle %0d: scoreboard empty, observed x/bv/busy/done=%b", name, i, obs);
            end else begin
                exp = q.pop_front();
                if (obs !== exp) begin
                    fails++;
                    $display("FAIL %s cycle %0d: observed x/bv/busy/done=%b required %b", name, i, obs, exp);
                end
            end
            @(posedge clk); #1;
        end
    endtask
    task automatic do_start(logic [LEN-1:0] pat, logic [CW-1:0] n);
        bus.pattern = pat;
        bus.nbits   = n;
        bus.start   = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask
    task automatic test_reset();
        bus.start = 1'b1; bus.pattern = 8'hFF; bus.nbits = 4'd8; bus.repeat_en = 1'b0;
        #2;
        tests++;
        if ({bus.x, bus.bit_valid, bus.busy, bus.done} !== 4'b0000) begin
            fails++;
            $display("FAIL reset: observed %b required 0000", {bus.x, bus.bit_valid, bus.busy, bus.done});
        end
        bus.start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        push_idle(2);
        check_cycles("reset_release", 2);
    endtask
    task automatic test_basic();
        push_xfer(8'hB2, 8, 1, 1);
        push_idle(2);
        do_start(8'hB2, 8);
        check_cycles("basic", 27);
    endtask
    task automatic test_short();
        push_xfer(8'hA7, 3, 1, 1);
        push_idle(1);
        do_start(8'hA7, 3);
        check_cycles("short", 11);
    endtask
    task automatic test_illegal();
        push_idle(6);
        bus.pattern = 8'hFF;
        bus.nbits   = 4'd0;
        bus.start   = 1'b1;
        check_cycles("illegal_n0", 3);
        bus.nbits = 4'd9;
        check_cycles("illegal_n9", 3);
        bus.start = 1'b0;
    endtask
    task automatic test_start_busy();
        push_xfer(8'hB2, 8, 1, 1);
        push_idle(1);
        do_start(8'hB2, 8);
        check_cycles("busy_a", 5);
        bus.start = 1'b1; bus.pattern = 8'h55; bus.nbits = 4'd3;
        check_cycles("busy_start", 3);
        bus.start = 1'b0;
        check_cycles("busy_b", 18);
    endtask
    task automatic test_repeat();
        bus.repeat_en = 1'b1;
        push_xfer(8'h02, 2, 3, 1);
        push_idle(1);
        do_start(8'h02, 2);
        check_cycles("repeat", 14);
        bus.repeat_en = 1'b0;
        check_cycles("repeat_stop", 6);
    endtask
    task automatic test_reset_mid();
        push_xfer(8'hB2, 8, 1, 0);
        do_start(8'hB2, 8);
        check_cycles("pre_reset", 9);
        rst = 1'b0;
        #1;
        tests++;
        if ({bus.x, bus.bit_valid, bus.busy, bus.done} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_mid: observed %b required 0000", {bus.x, bus.bit_valid, bus.busy, bus.done});
        end
        q.delete();
        @(posedge clk); #1;
        rst = 1'b1;
        push_idle(30);
        check_cycles("post_reset", 30);
    endtask
    task automatic test_back_to_back();
        push_xfer(8'hB2, 8, 1, 1);
        push_xfer(8'h05, 3, 1, 1);
        push_idle(1);
        do_start(8'hB2, 8);
        check_cycles("b2b_a", 24);
        bus.pattern = 8'h05; bus.nbits = 4'd3; bus.start = 1'b1;
        check_cycles("b2b_done", 1);
        bus.start = 1'b0;
        check_cycles("b2b_b", 11);
    endtask
    initial begin
        test_reset();
        test_basic();
        test_short();
        test_illegal();
        test_start_busy();
        test_repeat();
        test_reset_mid();
        test_back_to_back();
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL leftover: observed %0d queued entries required 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
    initial begin
        #100000;
        $display("FAIL timeout: observed no completion required finish before 100000");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/seq_pattern_tx.md
# seq_pattern_tx

Serial pattern transmitter that drives the input bit stream of the team's 7-state serial sequence detector. It shifts out a programmable 1..LEN-bit pattern, MSB first. Each bit is held for DIV clocks, which matches the detector's divided sampling rate. A start/busy/done handshake controls the transfer, and an optional repeat mode supports continuous stimulus and board demos.

## Interface
- DIV, default 3: clocks per transmitted bit; legal range ≥ 1.
- LEN, default 8: maximum pattern length in bits; legal range ≥ 1.
- CW, default $clog2(LEN)+1: width of the nbits port. Derived; do not override.
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  request a transfer. Sampled on the rising edge of clk.
- pattern  in  LEN  bits to send. Latched at accepted start.
- nbits  in  CW  number of bits to send; legal range 1..LEN. Latched at accepted start.
- repeat_en  in  1  when high at the end of the last bit, the latched pattern restarts with no gap.
- x  out  1  serial output bit.
- bit_valid  out  1  one-clock pulse on the first cycle of every transmitted bit.
- busy  out  1  high while a transfer is in progress.
- done  out  1  one-clock pulse when a transfer completes without repeat.

## Operation
- FSM states: IDLE, SEND.
- Reset (rst low, asynchronous): state=IDLE, x=0, bit_valid=0, busy=0, done=0, divider=0, bit index=0, latched registers=0. Release is synchronous to the next rising edge of clk.
- IDLE → SEND:
  - Condition: start=1 and 1 ≤ nbits ≤ LEN.
  - Latch pattern into pat_q and nbits into n_q.
  - Set idx = n_q−1 and divider = 0.
- IDLE with start=1 and (nbits=0 or nbits>LEN): start is ignored, no output change, state stays IDLE.
- SEND:
  - x = pat_q[idx].
  - divider counts 0..DIV−1 and wraps.
  - bit_valid = 1 when divider=0.
- End of bit (divider=DIV−1):
  - If idx>0: decrement idx.
  - If idx=0 and repeat_en=1: set idx=n_q−1 and stay in SEND. The next bit_valid follows immediately, with no idle cycle.
  - If idx=0 and repeat_en=0: go to IDLE.
- While busy=1:
  - start is ignored.
  - Changes on pattern and nbits have no effect.
  - repeat_en is sampled only at the end of the last bit.
- In IDLE: x=0, busy=0, bit_valid=0.
- done = 1 for exactly the first IDLE cycle after a SEND→IDLE transition. It is registered, not combinational.
- A start sampled during that done cycle is accepted normally. This allows back-to-back transfers with a one-cycle gap.
- Reset asserted mid-transfer: all outputs go to their reset values immediately. done is not pulsed, and the partial pattern is discarded.
- DIV=1: every SEND cycle is a new bit, so bit_valid stays high for the whole transfer.

## Timing
- Start sampled high at edge k (accepted). Then:
  - From edge k+1: busy=1, bit_valid=1, x = pattern[nbits−1].
  - Bit j (j = 0 for the first bit) is held on cycles k+1+j·DIV through k+(j+1)·DIV.
  - bit_valid pulses on cycle k+1+j·DIV.
- Without repeat, busy falls and done pulses at edge k+1+nbits·DIV.
- Total busy time is nbits·DIV clocks.
- Latency from start to first bit is 1 clock.
- With repeat, the period is exactly nbits·DIV clocks, and busy never drops.
- All outputs are registered, so there are no combinational paths from inputs to outputs.

## Test plan
- Basic transfer:
  - Stimulus: DIV=3, LEN=8, pattern=8'b1011_0010, nbits=8, start pulsed at cycle 0.
  - Required: x = 1,0,1,1,0,0,1,0, each bit held 3 clocks during cycles 1–24; bit_valid pulses at cycles 1,4,…,22; busy high for cycles 1–24; done=1 only at cycle 25.
- Short pattern into the detector:
  - Stimulus: nbits=3, pattern=3'b111, output fed to the sequence detector with matching divider.
  - Required: the detector's z asserts after the 3rd bit (s0→s1→s3→s5).
- Illegal lengths and start while busy:
  - Stimulus: start with nbits=0, then start with nbits=9 (LEN=8).
  - Required: busy stays 0 and x stays 0 for both.
  - Stimulus: start again while busy.
  - Required: the sequence is unchanged.
- Repeat mode:
  - Stimulus: pattern=2'b10, nbits=2, repeat_en=1.
  - Required: x = 1,0,1,0,… with period 6 clocks and no gap.
  - Stimulus: drop repeat_en mid-period.
  - Required: the current period finishes, then done pulses.
- Reset mid-transfer and back-to-back start:
  - Stimulus: rst low at cycle 10 of an 8-bit transfer.
  - Required: x, busy, bit_valid, and done are 0 in the same cycle; no done pulse after release.
  - Stimulus: start asserted during the done cycle.
  - Required: the new transfer begins on the next cycle.
